// File: rtl/awb_pkg.sv
// AWB gain scheduler shared types and constants.
// Holds the FSM states, channel select and gain defaults.
package awb_pkg;

  localparam int PRECISION = 16;
  localparam int FRAC_BITS = 8;

  localparam logic [15:0] DIV_ZERO_GAIN = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV_R,
    DIV_G,
    DIV_B,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } ch_e;

  function automatic logic [15:0] sat_gain(
    input logic [15:0] q,
    input logic [15:0] max
  );
    return (q > max) ? max : q;
  endfunction

endpackage

// File: rtl/awb_serial_div.sv
// Restoring serial divider, one quotient bit per cycle, MSB first.
// Ports: clk, rst, start, dividend[15:0], divisor[7:0] -> done, quotient[15:0].
module awb_serial_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        done,
  output logic [15:0] quotient
);
  import awb_pkg::*;

  logic [7:0]  rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  logic [8:0]  shifted;
  logic [8:0]  diff;
  logic        ge;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    shifted = {rem_q, quo_q[15]};
    diff    = shifted - {1'b0, divisor};
    ge      = (shifted >= {1'b0, divisor});
    if (start && !run_q) begin
      rem_d = '0;
      quo_d = dividend;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      // remainder stays below divisor, so bit 8 is zero
      // whenever the subtraction is skipped
      rem_d = ge ? diff[7:0] : shifted[7:0];
      quo_d = {quo_q[14:0], ge};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) run_d = 1'b0;
    end
  end

  // done and quotient are valid during the 16th iteration cycle
  assign done     = run_q && (cnt_q == 4'd15);
  assign quotient = quo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/awb_gain_scheduler.sv
// AWB gain scheduler: K_c = avg(R,G,B)/mean_c in Q8.8, R,G,B in turn
// through one serial divider; gains publish together with finish_o.
// Ports: clk, rst, valid_i, r/g/b_mean_i -> busy_o, finish_o, K_R/G/B_o.
// Build option GAIN_CLAMP_EN saturates every gain to MAX_GAIN.
module awb_gain_scheduler #(
  parameter int          PRECISION = 16,
  parameter int          FRAC_BITS = 8,
  parameter logic [15:0] MAX_GAIN  = 16'h0400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [7:0]           r_mean_i,
  input  logic [7:0]           g_mean_i,
  input  logic [7:0]           b_mean_i,
  output logic                 busy_o,
  output logic                 finish_o,
  output logic [PRECISION-1:0] K_R_o,
  output logic [PRECISION-1:0] K_G_o,
  output logic [PRECISION-1:0] K_B_o
);
  import awb_pkg::*;

  state_e state_q, state_d;
  logic   started_q, started_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [PRECISION-1:0] dvd_q, dvd_d;
  logic [PRECISION-1:0] shr_q, shr_d, shg_q, shg_d, shb_q, shb_d;
  logic [PRECISION-1:0] kr_q, kr_d, kg_q, kg_d, kb_q, kb_d;
  logic   busy_q, busy_d;
  logic   fin_q, fin_d;

  ch_e         ch;
  logic [7:0]  divisor;
  logic [9:0]  sum;
  logic [7:0]  avg;
  logic        div_start;
  logic        div_done;
  logic [15:0] div_quo;
  logic [15:0] gain_div;
  logic [15:0] gain_zero;
  logic [15:0] new_gain;
  logic        adv;

`ifdef GAIN_CLAMP_EN
  assign gain_div  = sat_gain(div_quo, MAX_GAIN);
  assign gain_zero = sat_gain(DIV_ZERO_GAIN, MAX_GAIN);
`else
  logic unused_max;
  assign unused_max = ^MAX_GAIN;
  assign gain_div   = div_quo;
  assign gain_zero  = DIV_ZERO_GAIN;
`endif

  assign sum = {2'b0, r_q} + {2'b0, g_q} + {2'b0, b_q};
  assign avg = 8'(sum / 10'd3);

  always_comb begin
    unique case (state_q)
      DIV_G:   ch = CH_G;
      DIV_B:   ch = CH_B;
      default: ch = CH_R;
    endcase
    unique case (ch)
      CH_G:    divisor = g_q;
      CH_B:    divisor = b_q;
      default: divisor = r_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    started_d = started_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    dvd_d     = dvd_q;
    shr_d     = shr_q;
    shg_d     = shg_q;
    shb_d     = shb_q;
    kr_d      = kr_q;
    kg_d      = kg_q;
    kb_d      = kb_q;
    fin_d     = 1'b0;
    div_start = 1'b0;
    new_gain  = '0;
    adv       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          r_d     = r_mean_i;
          g_d     = g_mean_i;
          b_d     = b_mean_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        dvd_d   = {avg, FRAC_BITS'(0)};
        state_d = DIV_R;
      end
      DIV_R, DIV_G, DIV_B: begin
        if (divisor == 8'd0) begin
          new_gain = gain_zero;
          adv      = 1'b1;
        end else if (!started_q) begin
          div_start = 1'b1;
          started_d = 1'b1;
        end else if (div_done) begin
          new_gain  = gain_div;
          started_d = 1'b0;
          adv       = 1'b1;
        end
        if (adv) begin
          unique case (ch)
            CH_G: begin
              shg_d   = new_gain;
              state_d = DIV_B;
            end
            CH_B: begin
              shb_d   = new_gain;
              state_d = DONE;
            end
            default: begin
              shr_d   = new_gain;
              state_d = DIV_G;
            end
          endcase
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    // gains and finish_o become visible together in the DONE cycle
    if (state_d == DONE) begin
      fin_d = 1'b1;
      kr_d  = shr_d;
      kg_d  = shg_d;
      kb_d  = shb_d;
    end
  end

  awb_serial_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dvd_q),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      dvd_q     <= '0;
      shr_q     <= '0;
      shg_q     <= '0;
      shb_q     <= '0;
      kr_q      <= '0;
      kg_q      <= '0;
      kb_q      <= '0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      dvd_q     <= dvd_d;
      shr_q     <= shr_d;
      shg_q     <= shg_d;
      shb_q     <= shb_d;
      kr_q      <= kr_d;
      kg_q      <= kg_d;
      kb_q      <= kb_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
    end
  end

  assign busy_o   = busy_q;
  assign finish_o = fin_q;
  assign K_R_o    = kr_q;
  assign K_G_o    = kg_q;
  assign K_B_o    = kb_q;

endmodule

// File: tb/tb_awb_gain_scheduler.sv
// Testbench for awb_gain_scheduler: directed and random frames checked
// against an arithmetic gain/latency model.
module tb_awb_gain_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [7:0]  r_mean_i = '0;
  logic [7:0]  g_mean_i = '0;
  logic [7:0]  b_mean_i = '0;
  logic        busy_o;
  logic        finish_o;
  logic [15:0] K_R_o, K_G_o, K_B_o;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_r = 16'h0, exp_g = 16'h0, exp_b = 16'h0;

  awb_gain_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .r_mean_i (r_mean_i),
    .g_mean_i (g_mean_i),
    .b_mean_i (b_mean_i),
    .busy_o   (busy_o),
    .finish_o (finish_o),
    .K_R_o    (K_R_o),
    .K_G_o    (K_G_o),
    .K_B_o    (K_B_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_gain(input int r, input int g,
                                           input int b, input int m);
    int avg;
    int k;
    avg = (r + g + b) / 3;
    if (m == 0) k = 65535;
    else k = (avg * 256) / m;
`ifdef GAIN_CLAMP_EN
    if (k > 1024) k = 1024;
`endif
    return 16'(k);
  endfunction

  task automatic do_run(input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit inject,
                        input int rst_at);
    int cyc;
    int fins;
    int first_fin;
    int busy_fall;
    int zeros;
    @(negedge clk);
    r_mean_i = r;
    g_mean_i = g;
    b_mean_i = b;
    valid_i  = 1'b1;
    @(negedge clk);
    valid_i   = 1'b0;
    cyc       = 1;
    fins      = 0;
    first_fin = 0;
    busy_fall = 0;
    chk("busy_load", busy_o, 1);
    zeros = int'(r == 0) + int'(g == 0) + int'(b == 0);
    while (cyc < 80) begin
      if (cyc == 2) begin
        chk("hold_r", K_R_o, exp_r);
        chk("hold_g", K_G_o, exp_g);
        chk("hold_b", K_B_o, exp_b);
      end
      if (finish_o) begin
        fins++;
        if (first_fin == 0) first_fin = cyc;
      end
      if (!busy_o && busy_fall == 0) busy_fall = cyc;
      if (rst == 1'b1) rst = 1'b0;
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_kr", K_R_o, 0);
        chk("rst_kg", K_G_o, 0);
        chk("rst_kb", K_B_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fin", finish_o, 0);
        exp_r = 16'h0;
        exp_g = 16'h0;
        exp_b = 16'h0;
      end
      valid_i = inject && (cyc == 20);
      if (inject && cyc == 20) begin
        r_mean_i = 8'd7;
        g_mean_i = 8'd3;
        b_mean_i = 8'd200;
      end
      @(negedge clk);
      cyc++;
    end
    valid_i = 1'b0;
    if (rst_at > 0) begin
      chk("rst_no_fin", fins, 0);
    end else begin
      exp_r = ref_gain(r, g, b, r);
      exp_g = ref_gain(r, g, b, g);
      exp_b = ref_gain(r, g, b, b);
      chk("fin_count", fins, 1);
      chk("fin_cycle", first_fin, 53 - 16 * zeros);
      chk("busy_fall", busy_fall, first_fin + 1);
    end
    chk("k_r", K_R_o, exp_r);
    chk("k_g", K_G_o, exp_g);
    chk("k_b", K_B_o, exp_b);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_fin", finish_o, 0);
    chk("reset_kr", K_R_o, 0);
    chk("reset_kg", K_G_o, 0);
    chk("reset_kb", K_B_o, 0);
    rst = 1'b0;

    do_run(8'd128, 8'd128, 8'd128, 1'b0, 0);
    do_run(8'd64, 8'd128, 8'd192, 1'b0, 0);
    do_run(8'd0, 8'd90, 8'd90, 1'b0, 0);
    do_run(8'd16, 8'd255, 8'd255, 1'b0, 0);
    do_run(8'd100, 8'd50, 8'd25, 1'b1, 0);
    do_run(8'd1, 8'd255, 8'd255, 1'b0, 0);
    do_run(8'd0, 8'd0, 8'd0, 1'b0, 0);
    do_run(8'd200, 8'd0, 8'd9, 1'b0, 0);
    do_run(8'd30, 8'd60, 8'd90, 1'b0, 30);
    do_run(8'd77, 8'd33, 8'd150, 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] r, g, b;
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) r = 8'd0;
      if ($urandom_range(0, 7) == 0) g = 8'd0;
      if ($urandom_range(0, 7) == 0) b = 8'd0;
      do_run(r, g, b, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/awb_gain_scheduler.md
# awb_gain_scheduler

Auto-white-balance gain controller: captures per-frame R/G/B channel means from the statistics stage and computes three gains through one shared serial divider. The gains are K_c = avg(R,G,B) / mean_c in unsigned Q8.8 format. Divisions run in time-multiplexed order R, G, B. The three gains publish atomically to the gain-apply stage.

## Interface
- PRECISION, 16, quotient width and divider iteration count.
- FRAC_BITS, 8, fractional bits of the gain; dividend = {avg, FRAC_BITS zeros}.
- MAX_GAIN, 16'h0400, clamp ceiling (4.0 in Q8.8); used only when the clamp macro is defined.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  single-cycle strobe; the means are sampled when valid_i=1 and busy_o=0.
- r_mean_i, g_mean_i, b_mean_i  in  8 each  channel means.
- busy_o  out  1  high from LOAD through DONE inclusive.
- finish_o  out  1  one-cycle pulse; gains updated this cycle.
- K_R_o, K_G_o, K_B_o  out  PRECISION each  Q8.8 gains, registered.

## Operation
- FSM states: IDLE, LOAD, DIV_R, DIV_G, DIV_B, DONE.
- IDLE: wait for valid_i. On valid_i, latch the three means and go to LOAD.
- LOAD (1 cycle):
  - sum = 10-bit r+g+b; avg = sum/3, truncated to 8 bits.
  - dividend = {avg, 8'd0}.
- DIV_c, nonzero mean:
  - Cycle 1: pulse div_start with dividend and the 8-bit divisor.
  - Wait for div_done.
  - Store the quotient in a shadow register, then advance to the next channel.
- DIV_c, mean == 0: no divider start. Shadow = 16'hFFFF. Advance after 1 cycle.
- DONE (1 cycle): copy the shadows to K_*_o, pulse finish_o, return to IDLE.
- Divider core: restoring, one quotient bit per cycle, MSB first, 16 iterations, truncating. Maximum quotient is 255*256/1 = 65280, which fits 16 bits with no overflow.
- valid_i while busy_o=1: ignored and dropped, with no effect on the calculation in progress.
- Outputs hold their last value between runs. No partial update is ever visible.

## Timing
- Cycle numbering: edge 0 samples valid_i. LOAD occupies cycle 1.
- Each nonzero channel occupies 17 cycles: start cycle plus 16 iterations, with done on the 16th.
  - DIV_R: cycles 2–18.
  - DIV_G: cycles 19–35.
  - DIV_B: cycles 36–52.
- DONE and finish_o: cycle 53 with all means nonzero. Each zero mean shortens the run by 16 cycles.
- busy_o falls in the cycle after DONE. A new valid_i is accepted in that same cycle.
- Reset values: state IDLE, busy_o=0, finish_o=0, K_R_o=K_G_o=K_B_o=0, shadows and divider cleared.
- Reset mid-run: immediate abort to the reset values. No finish_o pulse. The interrupted run is never resumed.

## Configuration
- GAIN_CLAMP_EN defined: each quotient, including the divide-by-zero value 16'hFFFF, is saturated to MAX_GAIN before it is stored to its shadow register.
- GAIN_CLAMP_EN undefined: raw 16-bit quotients are published, and divide-by-zero yields 16'hFFFF. MAX_GAIN is unused.
- Latency is identical in both builds.

## Structure
- Package awb_pkg holds:
  - the state enum;
  - PRECISION and FRAC_BITS defaults;
  - the DIV_ZERO_GAIN constant (16'hFFFF);
  - the channel-select enum (CH_R, CH_G, CH_B).
- Sub-module awb_serial_div is the divider core, shared by all three channels.
  - Ports: clk, rst, start, dividend[15:0], divisor[7:0], done, quotient[15:0].
  - A channel mux in the scheduler selects which mean drives its divisor input.

## Test plan
- Means 128/128/128 → finish_o at cycle 53; all gains 16'h0100.
- Means 64/128/192 → avg 128; K_R=16'h0200, K_G=16'h0100, K_B=16'h00AA.
- Means 0/90/90 → avg 60.
  - K_G=K_B=16'h00AA, K_R=16'hFFFF.
  - With GAIN_CLAMP_EN, K_R=16'h0400.
  - finish_o at cycle 37.
- Means 16/255/255 → avg 175; K_R=16'h0AF0 without the clamp, 16'h0400 with GAIN_CLAMP_EN; K_G=K_B=16'h00AF.
- Second valid_i at cycle 20 with different means → ignored. Outputs match the first set; only one finish_o pulse.
- rst asserted at cycle 30 of a run after a prior completed run → outputs 0, no finish_o. A fresh valid_i then completes normally.
